// File: rtl/regwr_pkg.sv
// Shared widths and request record for the register-file writeback arbiter.
package regwr_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned NUM_REQ    = 2;

   typedef struct packed {
      logic                  valid;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] data;
   } req_t;

endpackage

// File: rtl/regwr_slot.sv
// One-entry holding slot for a writeback channel; writes to register 0 are dropped at accept.
module regwr_slot
   import regwr_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk_i,
   input  logic              clr_ni,
   input  logic              valid_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              grant_i,
   output logic              ready_o,
   output logic              full_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_o
);

   logic              full_q, full_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              accept;

   // Draining and refilling in the same cycle keeps one accept per cycle.
   assign ready_o = !full_q || grant_i;
   assign accept  = valid_i && ready_o && (addr_i != '0);

   always_comb begin
      full_d = full_q;
      addr_d = addr_q;
      data_d = data_q;
      if (grant_i) begin
         full_d = 1'b0;
      end
      if (accept) begin
         full_d = 1'b1;
         addr_d = addr_i;
         data_d = data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!clr_ni) begin
         full_q <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign full_o = full_q;
   assign addr_o = addr_q;
   assign data_o = data_q;

endmodule

// File: rtl/regwr_arbiter.sv
// Round-robin arbiter merging two writeback channels onto one register-file write port.
// Optional destination scoreboard (claim/busy_map) is built when REGWR_SCOREBOARD_EN is defined.
module regwr_arbiter
   import regwr_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data
`ifdef REGWR_SCOREBOARD_EN
   ,
   input  logic                     claim_valid,
   input  logic [ADDR_W-1:0]        claim_addr,
   output logic [(1<<ADDR_W)-1:0]   busy_map
`endif
);

   logic              full0, full1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] data0, data1;
   logic              grant0, grant1;
   logic              last_grant_q, last_grant_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   regwr_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot0 (
      .clk_i   (clk),
      .clr_ni  (clr_n),
      .valid_i (req0_valid),
      .addr_i  (req0_addr),
      .data_i  (req0_data),
      .grant_i (grant0),
      .ready_o (req0_ready),
      .full_o  (full0),
      .addr_o  (addr0),
      .data_o  (data0)
   );

   regwr_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot1 (
      .clk_i   (clk),
      .clr_ni  (clr_n),
      .valid_i (req1_valid),
      .addr_i  (req1_addr),
      .data_i  (req1_data),
      .grant_i (grant1),
      .ready_o (req1_ready),
      .full_o  (full1),
      .addr_o  (addr1),
      .data_o  (data1)
   );

   // last_grant_q names the channel granted most recently; the other one wins a tie.
   always_comb begin
      grant0 = full0 && (!full1 || last_grant_q);
      grant1 = full1 && (!full0 || !last_grant_q);
   end

   always_comb begin
      last_grant_d = last_grant_q;
      wr_en_d      = grant0 || grant1;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      if (grant0) begin
         last_grant_d = 1'b0;
         wr_addr_d    = addr0;
         wr_data_d    = data0;
      end else if (grant1) begin
         last_grant_d = 1'b1;
         wr_addr_d    = addr1;
         wr_data_d    = data1;
      end
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         last_grant_q <= 1'b1;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

`ifdef REGWR_SCOREBOARD_EN
   logic [(1<<ADDR_W)-1:0] busy_q, busy_d;

   // A claim applied after the clear so a same-cycle re-claim keeps the bit set.
   always_comb begin
      busy_d = busy_q;
      if (wr_en_q) begin
         busy_d[wr_addr_q] = 1'b0;
      end
      if (claim_valid && (claim_addr != '0)) begin
         busy_d[claim_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_map = busy_q;
`endif

endmodule

// File: doc/regwr_arbiter.md
REGWR_ARBITER -- requirements
Module: regwr_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning the register index width (32 registers).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clr_n  input  1  meaning the reset, which is synchronous and active-low.
REQ-005 SHALL have ports req0_valid  input  1, req0_addr  input  ADDR_W and req0_data  input  DATA_W, meaning the ALU writeback request.
REQ-006 SHALL have port req0_ready  output  1  meaning channel 0 can accept a request this cycle.
REQ-007 SHALL have ports req1_valid  input  1, req1_addr  input  ADDR_W, req1_data  input  DATA_W and req1_ready  output  1, meaning the mult/div writeback channel.
REQ-008 SHALL have ports wr_en  output  1, wr_addr  output  ADDR_W and wr_data  output  DATA_W, meaning the single register-file write port (drives per-register en).
REQ-009 SHALL have ports claim_valid  input  1, claim_addr  input  ADDR_W and busy_map  output  2**ADDR_W, present only with REGWR_SCOREBOARD_EN, meaning the decode-stage destination claim and the pending-write bitmap.

Function
REQ-010 SHALL accept a request on a channel when valid and ready are both high at a rising edge.
REQ-011 SHALL hold each accepted request in a one-entry holding slot per channel.
REQ-012 SHALL drive readyN = !slotN_valid || grantN, so that back-to-back accepts run at 1 per cycle per channel.
REQ-013 SHALL discard an accepted request with addr 0: the slot is not filled and no wr_en is generated.
REQ-014 SHALL, each cycle, grant at most one non-empty slot combinationally and empty that slot at the next edge.
REQ-015 SHALL grant by round-robin: when both slots are full, grant the channel not granted last; when one is full, grant it.
REQ-016 SHALL update last_grant only on an actual grant.
REQ-017 SHALL register wr_en/wr_addr/wr_data from the granted slot, so that wr_en is high for exactly one cycle per grant.
REQ-018 SHALL have a latency of 2 cycles: a request accepted at edge N produces wr_en high during cycle N+1 to N+2 when uncontended.
REQ-019 SHALL hold wr_addr/wr_data at their last values while wr_en is low.
REQ-020 SHALL order same-address requests from both channels by grant order; the later write wins in the register file.
REQ-021 SHALL sustain a throughput of 1 write per cycle in aggregate; with both channels saturated, each channel receives 1 write per 2 cycles.

Reset
REQ-022 SHALL, while clr_n is low at an edge, clear both slots, set wr_en=0, wr_addr=0, wr_data=0, last_grant=1 (so channel 0 wins first) and busy_map=0.
REQ-023 SHALL drop any in-flight requests on reset mid-operation and not write them afterwards.
REQ-024 SHALL drive req0_ready=req1_ready=1 in the first cycle after reset.

Configuration
REQ-025 SHALL compile in the scoreboard only when REGWR_SCOREBOARD_EN is defined.
REQ-026 SHALL, with REGWR_SCOREBOARD_EN, set busy_map[claim_addr] on claim_valid (never bit 0) and clear busy_map[wr_addr] at the edge ending a wr_en cycle.
REQ-027 SHALL, with REGWR_SCOREBOARD_EN, keep the bit set when a claim and a clear hit the same address in the same cycle.
REQ-028 SHALL, without REGWR_SCOREBOARD_EN, not have the claim and busy_map ports, with the rest of the behaviour identical.

Structure
REQ-029 SHALL place DATA_W/ADDR_W defaults, NUM_REQ=2 and the request struct typedef (valid, addr, data) in shared package regwr_pkg.
REQ-030 SHALL implement the holding slot as sub-module regwr_slot, instantiated once per channel.

Verification
REQ-031 SHALL cover: reset then req0 {addr 5, data 0xDEADBEEF} -> wr_en high 2 cycles later with wr_addr=5, wr_data=0xDEADBEEF.
REQ-032 SHALL cover: both channels valid continuously (addr 3 / addr 7) -> writes alternate 3,7,3,7 starting with 3; each ready toggles.
REQ-033 SHALL cover: req1 valid with addr 0 -> accepted (ready high), wr_en never asserted.
REQ-034 SHALL cover: clr_n low for one cycle while both slots are full -> wr_en=0, no write of either entry; readys=1 next cycle.
REQ-035 SHALL cover (REGWR_SCOREBOARD_EN): claim addr 9, then req0 writes addr 9 -> busy_map[9]=1 until the edge after wr_en, then 0; a re-claim of 9 in that cycle keeps it 1.
REQ-036 SHALL cover: req0 alone for 8 consecutive cycles with incrementing data -> 8 consecutive wr_en cycles, data in order, no bubbles.
